// File: rtl/screen_frame_scheduler.sv
// ---------------------------------------------------------------------------
// screen_frame_scheduler
//
// Sequences the ST7735 screen_controller: panel reset and power-up timing,
// the controller enable, and full-frame raster writes. Each pixel is fetched
// from a pixel source with a req/valid handshake. It is then written to the
// controller with a wr_en/ready handshake. A frame starts on a request or on
// the free-running redraw timer.
//
// Ports
//   clk_main     in   1   system clock
//   rst_n        in   1   async active-low reset
//   frame_req    in   1   pulse: request one frame
//   auto_redraw  in   1   1 = start frames from the redraw timer
//   lcd_rst      out  1   panel reset pin, active-low
//   ctrl_enable  out  1   screen_controller enable
//   ctrl_ready   in   1   controller accepts a write when pix_wr_en & ctrl_ready
//   pix_x/pix_y  out  7   pixel address to the controller
//   pix_wr_en    out  1   pixel write strobe, held until accepted
//   pix_wr_data  out  16  RGB565 pixel data
//   src_req      out  1   pixel fetch request, held until src_valid
//   src_x/src_y  out  7   requested pixel address
//   src_valid    in   1   source data valid (sampled only while fetching)
//   src_data     in   16  RGB565 from the source
//   busy         out  1   1 from frame_start until frame_done
//   frame_start  out  1   1-cycle pulse when a frame begins
//   frame_done   out  1   1-cycle pulse when the last pixel is accepted
//
// State        | meaning
// -------------+------------------------------------------------------------
// S_PANEL_RST  | lcd_rst held low for RST_LOW_CYC cycles
// S_PANEL_WAIT | panel out of reset, waiting RST_WAIT_CYC before enabling
// S_IDLE       | controller enabled, waiting for a request or redraw tick
// S_FETCH      | src_req high, waiting for src_valid
// S_WRITE      | pix_wr_en high, waiting for ctrl_ready
// ---------------------------------------------------------------------------
module screen_frame_scheduler #(
    parameter int          WIDTH        = 128,
    parameter int          HEIGHT       = 128,
    parameter int          RST_LOW_CYC  = 4,
    parameter int          RST_WAIT_CYC = 16,
    parameter logic [23:0] FRAME_PERIOD = 24'h100000
) (
    input  logic        clk_main,
    input  logic        rst_n,
    input  logic        frame_req,
    input  logic        auto_redraw,
    output logic        lcd_rst,
    output logic        ctrl_enable,
    input  logic        ctrl_ready,
    output logic [6:0]  pix_x,
    output logic [6:0]  pix_y,
    output logic        pix_wr_en,
    output logic [15:0] pix_wr_data,
    output logic        src_req,
    output logic [6:0]  src_x,
    output logic [6:0]  src_y,
    input  logic        src_valid,
    input  logic [15:0] src_data,
    output logic        busy,
    output logic        frame_start,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_PANEL_RST,
        S_PANEL_WAIT,
        S_IDLE,
        S_FETCH,
        S_WRITE
    } state_t;

    localparam logic [15:0] RST_LOW_LAST  = 16'(RST_LOW_CYC - 1);
    localparam logic [15:0] RST_WAIT_LAST = 16'(RST_WAIT_CYC - 1);
    localparam logic [6:0]  X_LAST        = 7'(WIDTH - 1);
    localparam logic [6:0]  Y_LAST        = 7'(HEIGHT - 1);
    localparam logic [23:0] FRAME_LAST    = FRAME_PERIOD - 24'd1;

    state_t      r_state;
    logic [15:0] r_pwr_cnt;
    logic [23:0] r_redraw_cnt;
    logic [6:0]  r_x;
    logic [6:0]  r_y;
    logic        r_pending;

    logic        w_start;
    logic        w_x_last;
    logic        w_y_last;
    logic [6:0]  w_next_x;
    logic [6:0]  w_next_y;

    assign w_start  = r_pending | frame_req |
                      (auto_redraw & (r_redraw_cnt == FRAME_LAST));
    assign w_x_last = (r_x == X_LAST);
    assign w_y_last = (r_y == Y_LAST);
    assign w_next_x = w_x_last ? 7'd0 : r_x + 7'd1;
    assign w_next_y = w_x_last ? r_y + 7'd1 : r_y;

    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_PANEL_RST;
            r_pwr_cnt    <= '0;
            r_redraw_cnt <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_pending    <= 1'b0;
            lcd_rst      <= 1'b0;
            ctrl_enable  <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_wr_en    <= 1'b0;
            pix_wr_data  <= '0;
            src_req      <= 1'b0;
            src_x        <= '0;
            src_y        <= '0;
            busy         <= 1'b0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;

            // Outside IDLE a request is remembered (one deep); in IDLE it
            // starts the frame directly, which clears pending.
            if (frame_req && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_PANEL_RST: begin
                    if (r_pwr_cnt == RST_LOW_LAST) begin
                        lcd_rst   <= 1'b1;
                        r_pwr_cnt <= '0;
                        r_state   <= S_PANEL_WAIT;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + 16'd1;
                    end
                end

                S_PANEL_WAIT: begin
                    if (r_pwr_cnt == RST_WAIT_LAST) begin
                        ctrl_enable <= 1'b1;
                        r_pwr_cnt   <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + 16'd1;
                    end
                end

                S_IDLE: begin
                    if (w_start) begin
                        r_x          <= '0;
                        r_y          <= '0;
                        src_x        <= '0;
                        src_y        <= '0;
                        src_req      <= 1'b1;
                        frame_start  <= 1'b1;
                        busy         <= 1'b1;
                        r_pending    <= 1'b0;
                        r_redraw_cnt <= '0;
                        r_state      <= S_FETCH;
                    end else if (auto_redraw) begin
                        r_redraw_cnt <= r_redraw_cnt + 24'd1;
                    end else begin
                        r_redraw_cnt <= '0;
                    end
                end

                S_FETCH: begin
                    if (src_valid) begin
                        pix_wr_data <= src_data;
                        pix_x       <= r_x;
                        pix_y       <= r_y;
                        pix_wr_en   <= 1'b1;
                        src_req     <= 1'b0;
                        r_state     <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    if (ctrl_ready) begin
                        pix_wr_en <= 1'b0;
                        r_x       <= w_next_x;
                        r_y       <= w_next_y;
                        if (w_x_last && w_y_last) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            // Issue the next fetch straight from the write
                            // accept so a pixel costs two cycles minimum.
                            src_req <= 1'b1;
                            src_x   <= w_next_x;
                            src_y   <= w_next_y;
                            r_state <= S_FETCH;
                        end
                    end
                end

                default: r_state <= S_PANEL_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_frame_scheduler.sv
module tb_screen_frame_scheduler;

    localparam int W      = 8;
    localparam int H      = 4;
    localparam int NPIX   = W * H;

    logic        clk_main = 1'b0;
    logic        rst_n;
    logic        frame_req;
    logic        auto_redraw;
    logic        lcd_rst;
    logic        ctrl_enable;
    logic        ctrl_ready;
    logic [6:0]  pix_x;
    logic [6:0]  pix_y;
    logic        pix_wr_en;
    logic [15:0] pix_wr_data;
    logic        src_req;
    logic [6:0]  src_x;
    logic [6:0]  src_y;
    logic        src_valid;
    logic [15:0] src_data;
    logic        busy;
    logic        frame_start;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;
    int n_done   = 0;
    int mon_wr   = 0;
    logic [6:0] mon_x = '0;
    logic [6:0] mon_y = '0;

    // The pixel source returns its own address so every written pixel can be
    // checked against the raster position it belongs to.
    assign src_data = {2'b10, src_y, src_x};

    always #5 clk_main = ~clk_main;

    screen_frame_scheduler #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .RST_LOW_CYC  (4),
        .RST_WAIT_CYC (16),
        .FRAME_PERIOD (24'd8)
    ) u_dut (
        .clk_main    (clk_main),
        .rst_n       (rst_n),
        .frame_req   (frame_req),
        .auto_redraw (auto_redraw),
        .lcd_rst     (lcd_rst),
        .ctrl_enable (ctrl_enable),
        .ctrl_ready  (ctrl_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_wr_en   (pix_wr_en),
        .pix_wr_data (pix_wr_data),
        .src_req     (src_req),
        .src_x       (src_x),
        .src_y       (src_y),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .busy        (busy),
        .frame_start (frame_start),
        .frame_done  (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_main);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!frame_done && n < 400) begin
            tick();
            n++;
        end
        check(tag, frame_done, 1);
    endtask

    task automatic pulse_req();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
    endtask

    // Raster scoreboard: every accepted write must hit the next raster
    // position with that position's data; each frame must hold NPIX writes.
    always @(negedge clk_main) begin
        if (!rst_n) begin
            mon_x  = '0;
            mon_y  = '0;
            mon_wr = 0;
        end else begin
            if (frame_start) begin
                n_start++;
                mon_x  = '0;
                mon_y  = '0;
                mon_wr = 0;
            end
            if (pix_wr_en && ctrl_ready) begin
                check("wr_addr", {pix_y, pix_x}, {mon_y, mon_x});
                check("wr_data", pix_wr_data, {2'b10, mon_y, mon_x});
                mon_wr++;
                if (mon_x == 7'(W - 1)) begin
                    mon_x = '0;
                    mon_y = mon_y + 7'd1;
                end else begin
                    mon_x = mon_x + 7'd1;
                end
            end
            if (frame_done) begin
                n_done++;
                check("frame_wr_count", mon_wr, NPIX);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;

        rst_n       = 1'b0;
        frame_req   = 1'b0;
        auto_redraw = 1'b0;
        src_valid   = 1'b1;
        ctrl_ready  = 1'b1;
        repeat (3) tick();

        // Reset values
        check("rst_lcd_rst", lcd_rst, 0);
        check("rst_ctrl_enable", ctrl_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_strobes", {pix_wr_en, src_req, frame_start, frame_done}, 0);
        check("rst_addr", {pix_x, pix_y, src_x, src_y}, 0);
        check("rst_data", pix_wr_data, 0);

        // Reset release timing; a request during panel reset is kept pending
        rst_n = 1'b1;
        pulse_req();
        n = 1;
        while (!lcd_rst && n < 50) begin
            tick();
            n++;
        end
        check("lcd_rst_low_cycles", n, 4);
        n = 0;
        while (!ctrl_enable && n < 100) begin
            tick();
            n++;
        end
        check("enable_wait_cycles", n, 16);
        check("no_start_before_enable", n_start, 0);
        tick();
        check("pending_start", frame_start, 1);
        check("busy_on_start", busy, 1);

        // Full frame at 2 cycles per pixel
        n = 0;
        while (!frame_done && n < 400) begin
            tick();
            n++;
        end
        check("frame_cycles", n, 2 * NPIX);
        check("busy_at_done", busy, 0);
        tick();
        check("frame_done_count", n_done, 1);
        check("frame_done_pulse", frame_done, 0);

        // Fetch stall, then write stall at the end of line 0
        pulse_req();
        check("req_start", frame_start, 1);
        n = 0;
        while (!(src_req && src_x == 7'd2 && src_y == 7'd0) && n < 100) begin
            tick();
            n++;
        end
        check("reach_fetch_2_0", src_req, 1);
        src_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fetch_hold_req", src_req, 1);
            check("fetch_hold_addr", {src_y, src_x}, {7'd0, 7'd2});
            check("fetch_no_write", pix_wr_en, 0);
        end
        src_valid = 1'b1;
        n = 0;
        while (!(pix_wr_en && pix_x == 7'(W - 1) && pix_y == 7'd0) && n < 100) begin
            tick();
            n++;
        end
        check("reach_write_7_0", pix_wr_en, 1);
        ctrl_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_wr_en", pix_wr_en, 1);
            check("stall_addr", {pix_y, pix_x}, {7'd0, 7'(W - 1)});
            check("stall_data", pix_wr_data, {2'b10, 7'd0, 7'(W - 1)});
        end
        ctrl_ready = 1'b1;
        tick();
        check("wr_en_drop", pix_wr_en, 0);
        n = 0;
        while (!pix_wr_en && n < 20) begin
            tick();
            n++;
        end
        check("next_line_addr", {pix_y, pix_x}, {7'd1, 7'd0});
        wait_done("stall_frame_done");
        tick();

        // Auto redraw: 8 idle cycles between frame_done and frame_start
        auto_redraw = 1'b1;
        wait_done("auto_first_done");
        n = 0;
        while (!frame_start && n < 50) begin
            tick();
            n++;
        end
        check("auto_idle_cycles", n, 8);
        auto_redraw = 1'b0;
        wait_done("auto_second_done");
        tick();
        base = n_start;
        repeat (30) tick();
        check("auto_off_no_start", n_start, base);

        // Merged requests mid-frame, then a request at frame_done
        base = n_start;
        pulse_req();
        repeat (10) tick();
        for (int i = 0; i < 3; i++) begin
            pulse_req();
            tick();
            tick();
        end
        wait_done("merge_first_done");
        tick();
        check("merge_extra_start", frame_start, 1);
        wait_done("merge_extra_done");
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        check("req_at_done_start", frame_start, 1);
        wait_done("req_at_done_frame");
        repeat (30) tick();
        check("merge_total_frames", n_start - base, 3);

        // Reset mid-frame at pixel (5,3)
        pulse_req();
        n = 0;
        while (!(pix_wr_en && pix_x == 7'd5 && pix_y == 7'd3) && n < 200) begin
            tick();
            n++;
        end
        check("reach_write_5_3", pix_wr_en, 1);
        rst_n = 1'b0;
        #1;
        check("abort_lcd_rst", lcd_rst, 0);
        check("abort_ctrl_enable", ctrl_enable, 0);
        check("abort_busy", busy, 0);
        check("abort_strobes", {pix_wr_en, src_req, frame_start, frame_done}, 0);
        check("abort_addr", {pix_x, pix_y, src_x, src_y}, 0);
        check("abort_data", pix_wr_data, 0);
        tick();
        tick();
        rst_n = 1'b1;
        base = n_start;
        n = 0;
        while (!lcd_rst && n < 50) begin
            tick();
            n++;
        end
        check("rerst_lcd_low_cycles", n, 4);
        n = 0;
        while (!ctrl_enable && n < 100) begin
            tick();
            n++;
        end
        check("rerst_enable_wait", n, 16);
        repeat (20) tick();
        check("rerst_no_start", n_start, base);
        check("rerst_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
